// File: rtl/neonfox_pkg.sv
// Shared NeonFox pipeline types: ALU NOP opcode, register index, stage tags,
// and the byte-mask / forwarding helpers used by operand fetch.
package neonfox_pkg;

  localparam logic [3:0] ALU_NOP = 4'b0111;

  typedef logic [3:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    logic     wb;
    reg_idx_t dst;
    logic     h_en;
    logic     l_en;
  } stage_tag_t;

  // Neither byte enable set means the ALU swapped bytes, so both bytes change.
  function automatic logic [1:0] write_mask(input stage_tag_t t);
    logic swap;
    swap = ~t.h_en & ~t.l_en;
    return {t.h_en | swap, t.l_en | swap};
  endfunction

  function automatic logic [15:0] fwd_operand(input stage_tag_t wb_tag, input reg_idx_t src,
                                               input logic [15:0] alu, input logic [15:0] rf);
    logic [1:0] m;
    logic       hit;
    hit = wb_tag.valid & wb_tag.wb & (wb_tag.dst == src);
    m   = write_mask(wb_tag) & {2{hit}};
    return {m[1] ? alu[15:8] : rf[15:8], m[0] ? alu[7:0] : rf[7:0]};
  endfunction

endpackage

// File: rtl/neonfox_regfile.sv
// 16x16 register file: two asynchronous read ports, one byte-masked write port.
module neonfox_regfile
  import neonfox_pkg::*;
#(
  parameter int REG_COUNT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  reg_idx_t    rd_addr_a,
  output logic [15:0] rd_data_a,
  input  reg_idx_t    rd_addr_b,
  output logic [15:0] rd_data_b,
  input  logic        wr_en,
  input  reg_idx_t    wr_addr,
  input  logic [1:0]  wr_mask,
  input  logic [15:0] wr_data
);

  logic [15:0] mem [REG_COUNT];

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) mem[i] <= '0;
    end else if (wr_en) begin
      if (wr_mask[1]) mem[wr_addr][15:8] <= wr_data[15:8];
      if (wr_mask[0]) mem[wr_addr][7:0]  <= wr_data[7:0];
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// NeonFox operand-fetch stage: register read with WB forwarding, a one-cycle
// bubble on back-to-back dependencies, and write-back of the ALU result.
module operand_fetch
  import neonfox_pkg::*;
#(
  parameter int REG_COUNT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  reg_idx_t    dec_src_a,
  input  reg_idx_t    dec_src_b,
  input  reg_idx_t    dec_dst,
  input  logic        dec_wb,
  input  logic [3:0]  dec_alu_op,
  input  logic [7:0]  dec_I_field,
  input  logic        dec_set_cc,
  input  logic        dec_h_en,
  input  logic        dec_l_en,
  input  logic        stall,
  input  logic [15:0] alu_out,
  output logic [15:0] in_a,
  output logic [15:0] in_b,
  output logic [3:0]  alu_op,
  output logic [7:0]  I_field,
  output logic        set_cc,
  output logic        h_en,
  output logic        l_en,
  output logic        data_hazard
);

  stage_tag_t  ex_q, wb_q;
  logic [15:0] rf_a, rf_b, opnd_a, opnd_b;
  logic        bubble;

  neonfox_regfile #(.REG_COUNT(REG_COUNT)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (dec_src_a),
    .rd_data_a (rf_a),
    .rd_addr_b (dec_src_b),
    .rd_data_b (rf_b),
    .wr_en     (wb_q.valid & wb_q.wb & ~stall),
    .wr_addr   (wb_q.dst),
    .wr_mask   (write_mask(wb_q)),
    .wr_data   (alu_out)
  );

  assign opnd_a = fwd_operand(wb_q, dec_src_a, alu_out, rf_a);
  assign opnd_b = fwd_operand(wb_q, dec_src_b, alu_out, rf_b);

  // Byte-agnostic match: the EX result is not on alu_out yet, so any overlap waits.
  assign bubble      = dec_valid & ex_q.valid & ex_q.wb &
                       ((ex_q.dst == dec_src_a) | (ex_q.dst == dec_src_b));
  assign dec_ready   = ~stall & ~bubble;
  assign data_hazard = stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= '0;
      wb_q    <= '0;
      in_a    <= '0;
      in_b    <= '0;
      alu_op  <= ALU_NOP;
      I_field <= '0;
      set_cc  <= 1'b0;
      h_en    <= 1'b0;
      l_en    <= 1'b0;
    end else if (!stall) begin
      wb_q <= ex_q;
      if (dec_valid && !bubble) begin
        ex_q    <= '{valid: 1'b1, wb: dec_wb, dst: dec_dst, h_en: dec_h_en, l_en: dec_l_en};
        in_a    <= opnd_a;
        in_b    <= opnd_b;
        alu_op  <= dec_alu_op;
        I_field <= dec_I_field;
        set_cc  <= dec_set_cc;
        h_en    <= dec_h_en;
        l_en    <= dec_l_en;
      end else begin
        ex_q    <= '0;
        in_a    <= '0;
        in_b    <= '0;
        alu_op  <= ALU_NOP;
        I_field <= '0;
        set_cc  <= 1'b0;
        h_en    <= 1'b0;
        l_en    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed, table-driven bench for operand_fetch; the bench plays the ALU by
// driving alu_out with the result of the instruction currently in WB.
module tb_operand_fetch;

  typedef struct {
    logic        v;
    logic [3:0]  sa, sb, dst;
    logic        wb;
    logic [3:0]  op;
    logic [7:0]  imm;
    logic        cc, h, l, st;
    logic [15:0] alu;
    logic        e_rdy;
    logic [15:0] e_a, e_b;
    logic [3:0]  e_op;
    logic [7:0]  e_imm;
    logic        e_cc, e_h, e_l;
  } vec_t;

  logic        clk, rst;
  logic        dec_valid, dec_ready, dec_wb, dec_set_cc, dec_h_en, dec_l_en, stall;
  logic [3:0]  dec_src_a, dec_src_b, dec_dst, dec_alu_op;
  logic [7:0]  dec_I_field;
  logic [15:0] alu_out, in_a, in_b;
  logic [3:0]  alu_op;
  logic [7:0]  I_field;
  logic        set_cc, h_en, l_en, data_hazard;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];
  vec_t s2;
  vec_t sv;

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_src_a(dec_src_a), .dec_src_b(dec_src_b), .dec_dst(dec_dst), .dec_wb(dec_wb),
    .dec_alu_op(dec_alu_op), .dec_I_field(dec_I_field), .dec_set_cc(dec_set_cc),
    .dec_h_en(dec_h_en), .dec_l_en(dec_l_en),
    .stall(stall), .alu_out(alu_out),
    .in_a(in_a), .in_b(in_b), .alu_op(alu_op), .I_field(I_field),
    .set_cc(set_cc), .h_en(h_en), .l_en(l_en), .data_hazard(data_hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t ins(input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] dst,
                               input logic wb, input logic [3:0] op, input logic [7:0] imm,
                               input logic cc, input logic h, input logic l,
                               input logic [15:0] alu, input logic rdy,
                               input logic [15:0] ea, input logic [15:0] eb);
    vec_t v;
    v.v = 1'b1; v.sa = sa; v.sb = sb; v.dst = dst; v.wb = wb; v.op = op; v.imm = imm;
    v.cc = cc; v.h = h; v.l = l; v.st = 1'b0; v.alu = alu; v.e_rdy = rdy;
    if (rdy) begin
      v.e_a = ea; v.e_b = eb; v.e_op = op; v.e_imm = imm; v.e_cc = cc; v.e_h = h; v.e_l = l;
    end else begin
      v.e_a = '0; v.e_b = '0; v.e_op = 4'b0111; v.e_imm = '0; v.e_cc = 0; v.e_h = 0; v.e_l = 0;
    end
    return v;
  endfunction

  function automatic vec_t nop(input logic [15:0] alu);
    vec_t v;
    v = ins(4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, alu, 1'b0, 16'd0, 16'd0);
    v.v = 1'b0;
    v.e_rdy = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one cycle of decoder/ALU inputs, checks the combinational outputs
  // just before the edge and the registered outputs just after it.
  task automatic applyStimulus(input vec_t v, input string tag);
    dec_valid = v.v; dec_src_a = v.sa; dec_src_b = v.sb; dec_dst = v.dst; dec_wb = v.wb;
    dec_alu_op = v.op; dec_I_field = v.imm; dec_set_cc = v.cc; dec_h_en = v.h; dec_l_en = v.l;
    stall = v.st; alu_out = v.alu;
    #4;
    checkOutput({tag, ".dec_ready"}, 16'(dec_ready), 16'(v.e_rdy));
    checkOutput({tag, ".data_hazard"}, 16'(data_hazard), 16'(v.st));
    @(posedge clk);
    #1;
    checkOutput({tag, ".in_a"}, in_a, v.e_a);
    checkOutput({tag, ".in_b"}, in_b, v.e_b);
    checkOutput({tag, ".alu_op"}, 16'(alu_op), 16'(v.e_op));
    checkOutput({tag, ".I_field"}, 16'(I_field), 16'(v.e_imm));
    checkOutput({tag, ".set_cc"}, 16'(set_cc), 16'(v.e_cc));
    checkOutput({tag, ".h_en"}, 16'(h_en), 16'(v.e_h));
    checkOutput({tag, ".l_en"}, 16'(l_en), 16'(v.e_l));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".in_a"}, in_a, 16'h0000);
    checkOutput({tag, ".in_b"}, in_b, 16'h0000);
    checkOutput({tag, ".alu_op"}, 16'(alu_op), 16'h0007);
    checkOutput({tag, ".I_field"}, 16'(I_field), 16'h0000);
    checkOutput({tag, ".set_cc"}, 16'(set_cc), 16'h0000);
    checkOutput({tag, ".h_en"}, 16'(h_en), 16'h0000);
    checkOutput({tag, ".l_en"}, 16'(l_en), 16'h0000);
  endtask

  initial begin
    // Reads of all 16 registers after reset, no write-back.
    for (int i = 0; i < 8; i++)
      vecs.push_back(ins(4'(2*i), 4'(2*i+1), 4'd0, 1'b0, 4'(i), 8'(16*i), 1'(i), 1'b1, 1'b1,
                         16'hDEAD, 1'b1, 16'h0000, 16'h0000));
    // r3 = 0x1234, two NOPs, then read r3 from the register file.
    vecs.push_back(ins(0, 0, 3, 1, 4'h1, 8'h11, 1, 1, 1, 16'hDEAD, 1, 16'h0000, 16'h0000));
    vecs.push_back(nop(16'h0000));
    vecs.push_back(nop(16'h1234));
    vecs.push_back(ins(3, 0, 5, 0, 4'h2, 8'h22, 0, 1, 1, 16'h0000, 1, 16'h1234, 16'h0000));
    // r1 producer immediately followed by a consumer: one bubble, then forward.
    vecs.push_back(ins(0, 0, 1, 1, 4'h3, 8'h33, 1, 1, 1, 16'h0000, 1, 16'h0000, 16'h0000));
    vecs.push_back(ins(1, 3, 6, 0, 4'h4, 8'h44, 0, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000));
    vecs.push_back(ins(1, 3, 6, 0, 4'h4, 8'h44, 0, 1, 1, 16'h5A5A, 1, 16'h5A5A, 16'h1234));
    // r2 = 0xAABB, then high-byte-only write 0x11CC read at distance 2.
    vecs.push_back(ins(0, 0, 2, 1, 4'h5, 8'h55, 0, 1, 1, 16'h0000, 1, 16'h0000, 16'h0000));
    vecs.push_back(nop(16'h0000));
    vecs.push_back(ins(0, 0, 2, 1, 4'h6, 8'h66, 1, 1, 0, 16'hAABB, 1, 16'h0000, 16'h0000));
    vecs.push_back(nop(16'h0000));
    vecs.push_back(ins(2, 1, 7, 0, 4'h8, 8'h77, 0, 1, 1, 16'h11CC, 1, 16'h11BB, 16'h5A5A));
    // Swap write (no byte enables) forwards both bytes, then regfile holds it.
    vecs.push_back(ins(0, 0, 2, 1, 4'h9, 8'h88, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000));
    vecs.push_back(nop(16'h0000));
    vecs.push_back(ins(2, 2, 8, 0, 4'hA, 8'h99, 1, 1, 1, 16'h7788, 1, 16'h7788, 16'h7788));
    vecs.push_back(ins(2, 3, 9, 0, 4'hB, 8'hAA, 0, 1, 1, 16'h0000, 1, 16'h7788, 16'h1234));

    rst = 1'b1;
    dec_valid = 0; dec_src_a = 0; dec_src_b = 0; dec_dst = 0; dec_wb = 0; dec_alu_op = 0;
    dec_I_field = 0; dec_set_cc = 0; dec_h_en = 0; dec_l_en = 0; stall = 0; alu_out = 0;
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("row%0d", i));

    // Stall for three cycles while WB holds the r4 write; EX holds a real op.
    applyStimulus(ins(0, 0, 4, 1, 4'h1, 8'h00, 0, 1, 1, 16'h0000, 1, 16'h0000, 16'h0000), "s1");
    s2 = ins(0, 0, 13, 0, 4'h5, 8'h5C, 1, 1, 0, 16'h0000, 1, 16'h0000, 16'h0000);
    applyStimulus(s2, "s2");
    sv = s2;
    sv.st = 1'b1; sv.sa = 4'd4; sv.alu = 16'hBEEF; sv.e_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(sv, $sformatf("stall%0d", k));
      checkOutput($sformatf("stall%0d.r4", k), dut.u_regfile.mem[4], 16'h0000);
    end
    applyStimulus(ins(4, 0, 11, 0, 4'h2, 8'h12, 0, 1, 1, 16'hBEEF, 1, 16'hBEEF, 16'h0000), "release");
    checkOutput("release.r4", dut.u_regfile.mem[4], 16'hBEEF);
    applyStimulus(ins(0, 4, 12, 0, 4'h3, 8'h34, 0, 1, 1, 16'h0000, 1, 16'h0000, 16'hBEEF), "after");

    // Reset mid-cycle with EX (r10) and WB (r9) both valid.
    applyStimulus(ins(0, 0, 9, 1, 4'h3, 8'h55, 1, 1, 1, 16'h0000, 1, 16'h0000, 16'h0000), "r1");
    applyStimulus(ins(0, 0, 10, 1, 4'h6, 8'hA5, 1, 1, 1, 16'h0000, 1, 16'h0000, 16'h0000), "r2");
    dec_valid = 1'b0;
    alu_out = 16'h9999;
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("midreset");
    checkOutput("midreset.r9", dut.u_regfile.mem[9], 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(ins(9, 10, 0, 0, 4'h1, 8'h00, 0, 1, 1, 16'h9999, 1, 16'h0000, 16'h0000), "post1");
    applyStimulus(ins(4, 3, 0, 0, 4'h1, 8'h00, 0, 1, 1, 16'h0000, 1, 16'h0000, 16'h0000), "post2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 20000");
    $fatal(1, "[TB] timeout");
  end

endmodule
